// File: rtl/draw_sched_pkg.sv
// Shared types and constants for the draw update scheduler: FSM state
// encoding, per-enemy payload layout and the debug view of the block.
package draw_sched_pkg;

    localparam int DEF_N_ENEMY = 5;

    // Per-enemy payload: {x[9:0], y[9:0], type[1:0], health[3:0]}
    localparam int SLOT_W = 26;
    localparam int X_LSB  = 16;
    localparam int Y_LSB  = 6;
    localparam int T_LSB  = 4;
    localparam int H_LSB  = 0;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        WINDOW = 2'd1,
        CLOSE  = 2'd2
    } sched_state_e;

    typedef struct packed {
        sched_state_e state;
        logic [9:0]   xpixel;
        logic [9:0]   ypixel;
    } sched_dbg_t;

    // Width of an index that addresses n requesters (at least one bit).
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/draw_update_scheduler_if.sv
// Request/grant bus between the enemy engines and the update scheduler.
//
// Handshake: a requester raises req[i] with wr_data slot i valid and holds
// both stable until it observes gnt[i] high for one cycle; it drops req[i]
// in the following cycle. A req[i] still high in the cycle after gnt[i]
// is a fresh request. gnt is one-hot and registered.
interface draw_update_scheduler_if
    import draw_sched_pkg::*;
#(
    parameter int N_ENEMY = DEF_N_ENEMY
);
    logic [N_ENEMY-1:0]        req;
    logic [N_ENEMY*SLOT_W-1:0] wr_data;
    logic [N_ENEMY-1:0]        gnt;

    modport master (output req, output wr_data, input gnt);
    modport slave  (input req, input wr_data, output gnt);
endinterface

// File: rtl/draw_update_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or
// after rr_ptr, wrapping to index 0, and reports it one-hot and as an index.
module rr_arbiter
    import draw_sched_pkg::*;
#(
    parameter int N     = DEF_N_ENEMY,
    parameter int PTR_W = ptr_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] idx,
    output logic             valid
);

    // Two passes: upper half from rr_ptr first, then the wrapped lower half.
    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!valid && req[i] && (i >= int'(rr_ptr))) begin
                grant[i] = 1'b1;
                idx      = PTR_W'(i);
                valid    = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!valid && req[i]) begin
                grant[i] = 1'b1;
                idx      = PTR_W'(i);
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/draw_update_scheduler.sv
// Tear-free update controller. Enemy engines post position/type/health
// through a req/gnt bus; updates are accepted one per clock, round-robin,
// only during the vertical-blanking window, so the compositor-facing
// shadow registers never change during active video.
// Optional macro DRAW_SCHED_FREEZE_EN adds a 'freeze' input that stops
// grants, shadow/frame_cnt/missed updates and frame_tick while high.
module draw_update_scheduler
    import draw_sched_pkg::*;
#(
    parameter int N_ENEMY  = DEF_N_ENEMY,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525,
    parameter int GUARD    = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [9:0]             xpixel,
    input  logic [9:0]             ypixel,
    draw_update_scheduler_if.slave bus,
`ifdef DRAW_SCHED_FREEZE_EN
    input  logic                   freeze,
`endif
    output logic [N_ENEMY*10-1:0]  x_mid,
    output logic [N_ENEMY*10-1:0]  y_mid,
    output logic [N_ENEMY*2-1:0]   typeout,
    output logic [N_ENEMY*4-1:0]   health,
    output logic                   frame_tick,
    output logic [7:0]             frame_cnt,
    output logic [N_ENEMY-1:0]     missed,
    output sched_dbg_t             dbg
);

    localparam int         PTR_W    = ptr_width(N_ENEMY);
    localparam logic [9:0] VBLANK_Y = 10'(V_ACTIVE);
    localparam logic [9:0] CLOSE_Y  = 10'(V_TOTAL - GUARD);

    sched_state_e       state;
    sched_state_e       state_next;
    logic               prev_in_vblank;
    logic               armed;
    logic [PTR_W-1:0]   rr_ptr;
    logic [N_ENEMY-1:0] gnt_q;

    logic               in_vblank;
    logic               close_cond;
    logic               open_window;
    logic               hold;
    logic               grant_en;
    logic               capture_missed;

    logic [N_ENEMY-1:0] arb_grant;
    logic [PTR_W-1:0]   arb_idx;
    logic               arb_valid;

`ifdef DRAW_SCHED_FREEZE_EN
    assign hold = freeze;
`else
    assign hold = 1'b0;
`endif

    assign in_vblank  = (ypixel >= VBLANK_Y);
    assign close_cond = (ypixel >= CLOSE_Y) || !in_vblank;
    // armed blocks a spurious rising edge when reset is released mid-vblank.
    assign open_window = (state == ACTIVE) && in_vblank && !prev_in_vblank && armed;

    rr_arbiter #(
        .N     (N_ENEMY),
        .PTR_W (PTR_W)
    ) u_arb (
        .req    (bus.req),
        .rr_ptr (rr_ptr),
        .grant  (arb_grant),
        .idx    (arb_idx),
        .valid  (arb_valid)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ACTIVE;
        else       state <= state_next;
    end

    // Next state and per-state enables; grants only in WINDOW before close.
    always_comb begin
        state_next     = state;
        grant_en       = 1'b0;
        capture_missed = 1'b0;
        case (state)
            ACTIVE: begin
                if (open_window) state_next = WINDOW;
            end
            WINDOW: begin
                if (close_cond) state_next = CLOSE;
                else            grant_en   = arb_valid && !hold;
            end
            CLOSE: begin
                capture_missed = !hold;
                state_next     = ACTIVE;
            end
            default: state_next = ACTIVE;
        endcase
    end

    // vblank edge tracking; arming requires one active-video line first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_in_vblank <= 1'b0;
            armed          <= 1'b0;
        end else begin
            prev_in_vblank <= in_vblank;
            if (!in_vblank) armed <= 1'b1;
        end
    end

    // Frame pulse and counter advance when the window opens.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_tick <= 1'b0;
            frame_cnt  <= 8'd0;
        end else begin
            frame_tick <= open_window && !hold;
            if (open_window && !hold) frame_cnt <= frame_cnt + 8'd1;
        end
    end

    // Registered one-hot grant and round-robin pointer advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_q  <= '0;
            rr_ptr <= '0;
        end else begin
            gnt_q <= grant_en ? arb_grant : '0;
            if (grant_en) begin
                rr_ptr <= (arb_idx == PTR_W'(N_ENEMY - 1)) ? '0 : arb_idx + PTR_W'(1);
            end
        end
    end

    assign bus.gnt = gnt_q;

    // Shadow capture of the granted slot's payload.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_mid   <= '0;
            y_mid   <= '0;
            typeout <= '0;
            health  <= '0;
        end else begin
            for (int i = 0; i < N_ENEMY; i++) begin
                if (grant_en && arb_grant[i]) begin
                    x_mid[i*10 +: 10]  <= bus.wr_data[i*SLOT_W + X_LSB +: 10];
                    y_mid[i*10 +: 10]  <= bus.wr_data[i*SLOT_W + Y_LSB +: 10];
                    typeout[i*2 +: 2]  <= bus.wr_data[i*SLOT_W + T_LSB +: 2];
                    health[i*4 +: 4]   <= bus.wr_data[i*SLOT_W + H_LSB +: 4];
                end
            end
        end
    end

    // Sticky record of requests still pending when the window closed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)               missed <= '0;
        else if (capture_missed) missed <= missed | bus.req;
    end

    assign dbg = '{state: state, xpixel: xpixel, ypixel: ypixel};

endmodule

// File: tb/tb_draw_update_scheduler.sv
// Directed bench for draw_update_scheduler. One clock per video line keeps
// frames short; each task drives a scenario and checks its results inline.
module tb_draw_update_scheduler;
    import draw_sched_pkg::*;

    localparam int N = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [9:0]    xpixel = '0;
    logic [9:0]    ypixel = '0;
    logic [N*10-1:0] x_mid, y_mid;
    logic [N*2-1:0]  typeout;
    logic [N*4-1:0]  health;
    logic            frame_tick;
    logic [7:0]      frame_cnt;
    logic [N-1:0]    missed;
    sched_dbg_t      dbg;
`ifdef DRAW_SCHED_FREEZE_EN
    logic freeze = 1'b0;
`endif

    draw_update_scheduler_if #(.N_ENEMY(N)) bus ();

    draw_update_scheduler #(.N_ENEMY(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .xpixel     (xpixel),
        .ypixel     (ypixel),
        .bus        (bus),
`ifdef DRAW_SCHED_FREEZE_EN
        .freeze     (freeze),
`endif
        .x_mid      (x_mid),
        .y_mid      (y_mid),
        .typeout    (typeout),
        .health     (health),
        .frame_tick (frame_tick),
        .frame_cnt  (frame_cnt),
        .missed     (missed),
        .dbg        (dbg)
    );

    int cmp_count = 0;
    int fail_count = 0;

    // Expected shadow contents (bench model).
    logic [N*10-1:0] ex, ey;
    logic [N*2-1:0]  et;
    logic [N*4-1:0]  eh;

    // ---------------- driver tasks ----------------
    // Present line y for one clock; returns #1 after the edge that consumed it.
    task automatic line(input int y);
        ypixel = 10'(y);
        xpixel = 10'(y * 3);
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int i, input int x, input int y, input int t, input int h);
        bus.wr_data[i*SLOT_W +: SLOT_W] = {10'(x), 10'(y), 2'(t), 4'(h)};
    endtask

    task automatic set_exp(input int i, input int x, input int y, input int t, input int h);
        ex[i*10 +: 10] = 10'(x);
        ey[i*10 +: 10] = 10'(y);
        et[i*2 +: 2]   = 2'(t);
        eh[i*4 +: 4]   = 4'(h);
    endtask

    task automatic clear_exp();
        ex = '0; ey = '0; et = '0; eh = '0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        bus.req = '0;
        bus.wr_data = '0;
        clear_exp();
        repeat (3) @(posedge clk);
        #1;
        cmp_count++;
        if ({bus.gnt, frame_tick, frame_cnt, missed} !== '0) begin
            $display("FAIL reset_ctrl: got %0h expected 0", {bus.gnt, frame_tick, frame_cnt, missed});
            fail_count++;
        end
        cmp_count++;
        if ({x_mid, y_mid, typeout, health} !== '0) begin
            $display("FAIL reset_shadow: got %0h expected 0", {x_mid, y_mid, typeout, health});
            fail_count++;
        end
        cmp_count++;
        if (dbg.state !== ACTIVE) begin
            $display("FAIL reset_state: got %0d expected %0d", dbg.state, ACTIVE);
            fail_count++;
        end
    endtask

    task automatic test_frame_sweep();
        int ticks = 0;
        int tick_y = -1;
        reset = 1'b0;
        for (int y = 0; y < 525; y++) begin
            line(y);
            if (frame_tick) begin
                ticks++;
                tick_y = y;
            end
            if (y < 480) begin
                cmp_count++;
                if ({bus.gnt, x_mid, y_mid, typeout, health, missed, frame_cnt} !== '0) begin
                    $display("FAIL sweep_active_zero: line %0d got nonzero outputs, expected 0", y);
                    fail_count++;
                end
            end
            if (y == 480 || y == 523 || y == 524) begin
                cmp_count++;
                if (dbg.state !== ((y == 480) ? WINDOW : (y == 523) ? CLOSE : ACTIVE)) begin
                    $display("FAIL sweep_state: line %0d got %0d", y, dbg.state);
                    fail_count++;
                end
            end
        end
        cmp_count++;
        if (ticks !== 1 || tick_y !== 480) begin
            $display("FAIL sweep_tick: got %0d ticks at %0d, expected 1 at 480", ticks, tick_y);
            fail_count++;
        end
        cmp_count++;
        if (frame_cnt !== 8'd1) begin
            $display("FAIL sweep_frame_cnt: got %0d expected 1", frame_cnt);
            fail_count++;
        end
    endtask

    task automatic test_single_request();
        logic [N-1:0] exp_g;
        for (int y = 0; y < 525; y++) begin
            if (y == 10) begin
                set_slot(2, 100, 200, 1, 9);
                bus.req[2] = 1'b1;
            end
            line(y);
            exp_g = (y == 481) ? 5'b00100 : 5'b00000;
            cmp_count++;
            if (bus.gnt !== exp_g) begin
                $display("FAIL single_gnt: line %0d got %b expected %b", y, bus.gnt, exp_g);
                fail_count++;
            end
            if (bus.gnt[2]) bus.req[2] = 1'b0;
            if (y == 481) set_exp(2, 100, 200, 1, 9);
            cmp_count++;
            if ({x_mid, y_mid, typeout, health} !== {ex, ey, et, eh}) begin
                $display("FAIL single_shadow: line %0d got x=%0h h=%0h expected x=%0h h=%0h", y, x_mid, health, ex, eh);
                fail_count++;
            end
        end
        cmp_count++;
        if (frame_cnt !== 8'd2) begin
            $display("FAIL single_frame_cnt: got %0d expected 2", frame_cnt);
            fail_count++;
        end
        // Shadows must hold through the following active frame.
        for (int y = 0; y < 480; y++) begin
            line(y);
            cmp_count++;
            if ({bus.gnt, x_mid, y_mid, typeout, health} !== {5'b0, ex, ey, et, eh}) begin
                $display("FAIL single_hold: line %0d got x=%0h gnt=%b expected x=%0h gnt=0", y, x_mid, bus.gnt, ex);
                fail_count++;
            end
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_seq [8];
        exp_seq = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001, 5'b00100, 5'b00000};
        reset = 1'b1;
        line(0);
        reset = 1'b0;
        clear_exp();
        for (int y = 1; y < 481; y++) line(y);
        for (int i = 0; i < N; i++) set_slot(i, 10 + i, 20 + i, i, i + 1);
        bus.req = 5'b11111;
        for (int k = 0; k < 8; k++) begin
            line(481 + k);
            cmp_count++;
            if (bus.gnt !== exp_seq[k]) begin
                $display("FAIL rr_gnt: step %0d got %b expected %b", k, bus.gnt, exp_seq[k]);
                fail_count++;
            end
            bus.req = bus.req & ~bus.gnt;
            if (k == 4) begin
                set_slot(0, 300, 301, 3, 12);
                set_slot(2, 302, 303, 2, 14);
                bus.req = 5'b00101;
            end
        end
        for (int i = 0; i < N; i++) set_exp(i, 10 + i, 20 + i, i, i + 1);
        set_exp(0, 300, 301, 3, 12);
        set_exp(2, 302, 303, 2, 14);
        cmp_count++;
        if ({x_mid, y_mid, typeout, health} !== {ex, ey, et, eh}) begin
            $display("FAIL rr_shadow: got x=%0h h=%0h expected x=%0h h=%0h", x_mid, health, ex, eh);
            fail_count++;
        end
        cmp_count++;
        if (frame_cnt !== 8'd1) begin
            $display("FAIL rr_frame_cnt: got %0d expected 1", frame_cnt);
            fail_count++;
        end
    endtask

    task automatic test_missed();
        for (int y = 489; y < 525; y++) begin
            if (y == 523) begin
                set_slot(4, 500, 5, 2, 7);
                bus.req[4] = 1'b1;
            end
            line(y);
            cmp_count++;
            if (bus.gnt !== 5'b0) begin
                $display("FAIL missed_gnt: line %0d got %b expected 0", y, bus.gnt);
                fail_count++;
            end
            if (y == 523) begin
                cmp_count++;
                if (missed !== 5'b0 || dbg.state !== CLOSE) begin
                    $display("FAIL missed_pre: got missed=%b state=%0d expected 0 and CLOSE", missed, dbg.state);
                    fail_count++;
                end
            end
            if (y == 524) begin
                cmp_count++;
                if (missed !== 5'b10000) begin
                    $display("FAIL missed_set: got %b expected 10000", missed);
                    fail_count++;
                end
            end
        end
        bus.req[4] = 1'b0;
        for (int y = 0; y < 525; y++) line(y);
        cmp_count++;
        if (missed !== 5'b10000) begin
            $display("FAIL missed_sticky: got %b expected 10000", missed);
            fail_count++;
        end
        cmp_count++;
        if ({x_mid, y_mid, typeout, health} !== {ex, ey, et, eh}) begin
            $display("FAIL missed_shadow: got h=%0h expected h=%0h", health, eh);
            fail_count++;
        end
        cmp_count++;
        if (frame_cnt !== 8'd2) begin
            $display("FAIL missed_frame_cnt: got %0d expected 2", frame_cnt);
            fail_count++;
        end
    endtask

    task automatic test_reset_mid_window();
        logic [N-1:0] exp_g;
        for (int y = 0; y < 490; y++) line(y);
        ypixel = 10'd490;
        #2;
        reset = 1'b1;
        #1;
        clear_exp();
        cmp_count++;
        if ({bus.gnt, frame_tick, frame_cnt, missed, x_mid, y_mid, typeout, health} !== '0) begin
            $display("FAIL midreset_async: got cnt=%0d missed=%b h=%0h expected all 0", frame_cnt, missed, health);
            fail_count++;
        end
        cmp_count++;
        if (dbg.state !== ACTIVE) begin
            $display("FAIL midreset_state: got %0d expected %0d", dbg.state, ACTIVE);
            fail_count++;
        end
        for (int y = 490; y < 495; y++) line(y);
        reset = 1'b0;
        set_slot(1, 7, 8, 1, 3);
        bus.req[1] = 1'b1;
        for (int y = 495; y < 525; y++) begin
            line(y);
            cmp_count++;
            if ({bus.gnt, frame_tick} !== '0) begin
                $display("FAIL midreset_no_window: line %0d got gnt=%b tick=%b expected 0", y, bus.gnt, frame_tick);
                fail_count++;
            end
        end
        cmp_count++;
        if (missed !== 5'b0 || frame_cnt !== 8'd0) begin
            $display("FAIL midreset_quiet: got missed=%b cnt=%0d expected 0 and 0", missed, frame_cnt);
            fail_count++;
        end
        for (int y = 0; y < 482; y++) begin
            line(y);
            exp_g = (y == 481) ? 5'b00010 : 5'b00000;
            cmp_count++;
            if (bus.gnt !== exp_g || frame_tick !== (y == 480)) begin
                $display("FAIL midreset_next: line %0d got gnt=%b tick=%b expected %b %b", y, bus.gnt, frame_tick, exp_g, (y == 480));
                fail_count++;
            end
            if (bus.gnt[1]) bus.req[1] = 1'b0;
        end
        set_exp(1, 7, 8, 1, 3);
        cmp_count++;
        if ({x_mid, y_mid, typeout, health} !== {ex, ey, et, eh} || frame_cnt !== 8'd1) begin
            $display("FAIL midreset_grant: got x=%0h cnt=%0d expected x=%0h cnt=1", x_mid, frame_cnt, ex);
            fail_count++;
        end
    endtask

`ifdef DRAW_SCHED_FREEZE_EN
    task automatic test_freeze();
        for (int y = 482; y < 525; y++) line(y);
        for (int y = 0; y < 470; y++) line(y);
        freeze = 1'b1;
        set_slot(0, 11, 22, 3, 15);
        bus.req[0] = 1'b1;
        for (int y = 470; y < 525; y++) begin
            line(y);
            cmp_count++;
            if ({bus.gnt, frame_tick} !== '0) begin
                $display("FAIL freeze_quiet: line %0d got gnt=%b tick=%b expected 0", y, bus.gnt, frame_tick);
                fail_count++;
            end
        end
        cmp_count++;
        if (frame_cnt !== 8'd1 || missed !== 5'b0) begin
            $display("FAIL freeze_hold: got cnt=%0d missed=%b expected 1 and 0", frame_cnt, missed);
            fail_count++;
        end
        cmp_count++;
        if ({x_mid, y_mid, typeout, health} !== {ex, ey, et, eh}) begin
            $display("FAIL freeze_shadow: got x=%0h expected x=%0h", x_mid, ex);
            fail_count++;
        end
        freeze = 1'b0;
        bus.req[0] = 1'b0;
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_frame_sweep();
        test_single_request();
        test_round_robin();
        test_missed();
        test_reset_mid_window();
`ifdef DRAW_SCHED_FREEZE_EN
        test_freeze();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

endmodule

// File: doc/draw_update_scheduler.md
Name: draw_update_scheduler

Overview:
- Tear-free update controller for the pixel compositor.
- Enemy engines (N_ENEMY requesters) post new position/type/health through a req/gnt handshake.
- The scheduler grants one requester per clock, round-robin, only inside the vertical-blanking window. It holds the compositor-facing shadow registers stable for the whole active frame.
- Sits between the game logic and the top-level drawing mux; also supplies frame_tick and frame_cnt to game logic.

Parameters:
- N_ENEMY, 5, number of requesters/slots.
- V_ACTIVE, 480, first ypixel value of vertical blanking.
- V_TOTAL, 525, lines per frame; ypixel runs 0..V_TOTAL-1.
- GUARD, 2, lines before V_TOTAL at which the update window closes.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-high.
- xpixel  in  10  current horizontal pixel from VGA driver (unused except for debug/assertions).
- ypixel  in  10  current vertical line from VGA driver.
- req  in  N_ENEMY  update request, one bit per enemy.
- wr_data  in  N_ENEMY*26  per-enemy payload, slot i = {x[9:0], y[9:0], type[1:0], health[3:0]} at bits [26i+25:26i].
- gnt  out  N_ENEMY  one-hot, one-cycle grant pulse.
- x_mid  out  N_ENEMY*10  shadow x per slot.
- y_mid  out  N_ENEMY*10  shadow y per slot.
- typeout  out  N_ENEMY*2  shadow type per slot.
- health  out  N_ENEMY*4  shadow health per slot.
- frame_tick  out  1  one-cycle pulse at window open.
- frame_cnt  out  8  frames since reset, wraps 255->0.
- missed  out  N_ENEMY  sticky: slot had req pending when window closed.

Behaviour:
- Reset (async): all outputs 0. Health 0 means enemy not drawn. FSM=ACTIVE, rr_ptr=0, prev_in_vblank=0.
- in_vblank = (ypixel >= V_ACTIVE). close_cond = (ypixel >= V_TOTAL-GUARD) or !in_vblank.
- FSM ACTIVE -> WINDOW on the rising edge of in_vblank (prev_in_vblank=0, in_vblank=1); frame_tick=1 and frame_cnt+1 registered on that edge.
- After reset released mid-vblank, no window opens until the next rising edge of in_vblank.
- FSM WINDOW -> CLOSE when close_cond. CLOSE -> ACTIVE next cycle.
- In CLOSE: missed[i] |= req[i] for all i. No grants in CLOSE or ACTIVE.
- WINDOW grant rule:
  - If |req and !close_cond, grant the first i with req[i]=1, searching from rr_ptr upward mod N_ENEMY.
  - gnt registered, asserts 1 cycle after the requesting cycle.
  - On that same edge: shadow slot i <= wr_data slot i as sampled in the requesting cycle; rr_ptr <= (i+1) mod N_ENEMY.
- Handshake:
  - Requester holds req and wr_data stable until it sees gnt, then drops req the next cycle.
  - If req is still high the cycle after gnt, it is a new request and may be granted again (rr order permitting).
- Latency: req in WINDOW with no contention -> gnt and shadow update 1 cycle later. Worst case N_ENEMY cycles.
- Shadow outputs change only in WINDOW. They are constant for every ypixel < V_ACTIVE.
- Simultaneous close_cond and req in the same cycle: no grant; the request is counted as missed in CLOSE.
- Widths: no arithmetic on payload; frame_cnt modulo 256.

Optional Feature:
- DRAW_SCHED_FREEZE_EN defined: adds input freeze (1b, game-over).
  - While freeze=1: no grants, shadows, frame_cnt and missed hold; frame_tick suppressed; FSM still tracks ypixel.
- Undefined: no freeze port; behaviour as above.

Decomposition:
- Package draw_sched_pkg: FSM state enum {ACTIVE, WINDOW, CLOSE}, SLOT_W=26, field offsets X_LSB=16, Y_LSB=6, T_LSB=4, H_LSB=0, default N_ENEMY.
- One sub-module: rr_arbiter (req, rr_ptr -> one-hot grant, granted index, valid), purely combinational.
- Shadow registers and FSM stay in draw_update_scheduler.

Test Plan:
- Reset, then ypixel sweep 0..524: frame_tick exactly once at ypixel=480; frame_cnt=1; all outputs 0 in active video.
- req[2]=1 at ypixel=10, payload x=100,y=200,type=1,health=9: no gnt until ypixel=480; gnt[2] next cycle; x_mid slot2=100, health=9; values unchanged through the next active frame.
- req=5'b11111 in window with rr_ptr=0: gnts 0,1,2,3,4 on consecutive cycles. Then req=5'b00101 with rr_ptr=0 after a grant to 4: order 0,2.
- req[4] asserted at ypixel=523 (close_cond): no grant; missed[4]=1 and stays 1 until reset.
- Reset asserted mid-window at ypixel=490 and released at 495: outputs 0 immediately, no window until the next frame's ypixel=480.
- With DRAW_SCHED_FREEZE_EN, freeze=1 through vblank with req[0]=1: no gnt, frame_cnt unchanged, shadows unchanged.
